// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, ALU control
// encodings and FSM state codes.
package alu_seq_pkg;

    // Request opcodes
    localparam logic [2:0] OPC_AND  = 3'b000;
    localparam logic [2:0] OPC_OR   = 3'b001;
    localparam logic [2:0] OPC_ADD  = 3'b010;
    localparam logic [2:0] OPC_MUL  = 3'b011;
    localparam logic [2:0] OPC_NOR  = 3'b100;
    localparam logic [2:0] OPC_RSVD = 3'b101;
    localparam logic [2:0] OPC_SUB  = 3'b110;
    localparam logic [2:0] OPC_SLT  = 3'b111;

    // ALU function select
    localparam logic [1:0] ALUOP_AND = 2'b00;
    localparam logic [1:0] ALUOP_OR  = 2'b01;
    localparam logic [1:0] ALUOP_ADD = 2'b10;
    localparam logic [1:0] ALUOP_SLT = 2'b11;

    // Complete control word presented to the external ALU
    typedef struct packed {
        logic       ainvert;
        logic       bnegate;
        logic [1:0] op;
    } alu_ctrl_t;

    localparam alu_ctrl_t CTRL_IDLE = '{ainvert: 1'b0, bnegate: 1'b0, op: ALUOP_AND};
    localparam alu_ctrl_t CTRL_ADD  = '{ainvert: 1'b0, bnegate: 1'b0, op: ALUOP_ADD};

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    // Plain constants used for the state register (legacy-compatible coding)
    localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
    localparam logic [1:0] S_EXEC = 2'(ST_EXEC);
    localparam logic [1:0] S_MUL  = 2'(ST_MUL);
    localparam logic [1:0] S_DONE = 2'(ST_DONE);

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and response signals of the ALU operation sequencer.
// slave: the sequencer itself; master: the requester / ALU environment.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 32
);
    // Request channel
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_opcode;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    // Drive to the external combinational ALU
    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic             alu_ainvert;
    logic             alu_bnegate;
    logic [1:0]       alu_op;

    // Results coming back from the ALU in the same cycle
    logic [WIDTH-1:0] alu_result;
    logic             alu_overflow;
    logic             alu_zero;

    // Response channel
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_overflow;
    logic             rsp_zero;
    logic             rsp_err;

    modport slave (
        input  req_valid, req_opcode, req_a, req_b,
        output req_ready,
        output alu_in1, alu_in2, alu_ainvert, alu_bnegate, alu_op,
        input  alu_result, alu_overflow, alu_zero,
        output rsp_valid, rsp_result, rsp_overflow, rsp_zero, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_opcode, req_a, req_b,
        input  req_ready,
        input  alu_in1, alu_in2, alu_ainvert, alu_bnegate, alu_op,
        output alu_result, alu_overflow, alu_zero,
        input  rsp_valid, rsp_result, rsp_overflow, rsp_zero, rsp_err,
        output rsp_ready
    );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode decode: ALU control word plus multi-cycle and
// reserved-opcode flags.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [2:0] opcode,
    output alu_ctrl_t  ctrl,
    output logic       is_mul,
    output logic       is_rsvd
);

    // Map each opcode to its ALU control word; MUL and reserved drive idle controls
    always_comb begin
        ctrl    = CTRL_IDLE;
        is_mul  = 1'b0;
        is_rsvd = 1'b0;
        case (opcode)
            OPC_AND: ctrl = '{ainvert: 1'b0, bnegate: 1'b0, op: ALUOP_AND};
            OPC_OR:  ctrl = '{ainvert: 1'b0, bnegate: 1'b0, op: ALUOP_OR};
            OPC_ADD: ctrl = '{ainvert: 1'b0, bnegate: 1'b0, op: ALUOP_ADD};
            OPC_SUB: ctrl = '{ainvert: 1'b0, bnegate: 1'b1, op: ALUOP_ADD};
            OPC_SLT: ctrl = '{ainvert: 1'b0, bnegate: 1'b1, op: ALUOP_SLT};
            OPC_NOR: ctrl = '{ainvert: 1'b1, bnegate: 1'b1, op: ALUOP_AND};
            OPC_MUL: is_mul = 1'b1;
            default: is_rsvd = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts one request at a time, runs it through an
// external combinational ALU (single pass, or WIDTH shift-add passes for MUL)
// and holds the result on a valid/ready response channel.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [1:0]              state_q;
    alu_ctrl_t               ctrl_q;
    // Operand registers; during MUL a_q is the shifting multiplicand and
    // b_q the shifting multiplier
    logic signed [WIDTH-1:0] a_q;
    logic signed [WIDTH-1:0] b_q;
    logic [WIDTH-1:0]        acc_q;
    logic [CNT_W-1:0]        cnt_q;

    logic [WIDTH-1:0]        rsp_result_q;
    logic                    rsp_overflow_q;
    logic                    rsp_zero_q;
    logic                    rsp_err_q;

    alu_ctrl_t               dec_ctrl;
    logic                    dec_is_mul;
    logic                    dec_is_rsvd;

    alu_ctrl_t               drv_ctrl;
    logic [WIDTH-1:0]        drv_in1;
    logic [WIDTH-1:0]        drv_in2;
    logic                    last_iter;

    // Decode the incoming opcode so the control word is captured at accept
    alu_op_decode u_decode (
        .opcode  (bus.req_opcode),
        .ctrl    (dec_ctrl),
        .is_mul  (dec_is_mul),
        .is_rsvd (dec_is_rsvd)
    );

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // ALU drive: quiet in IDLE/DONE, operands in EXEC, accumulate step in MUL
    always_comb begin
        drv_ctrl = CTRL_IDLE;
        drv_in1  = '0;
        drv_in2  = '0;
        case (state_q)
            S_EXEC: begin
                drv_ctrl = ctrl_q;
                drv_in1  = a_q;
                drv_in2  = b_q;
            end
            S_MUL: begin
                drv_ctrl = CTRL_ADD;
                drv_in1  = acc_q;
                drv_in2  = b_q[0] ? a_q : '0;
            end
            default: ;
        endcase
    end

    assign bus.alu_in1     = drv_in1;
    assign bus.alu_in2     = drv_in2;
    assign bus.alu_ainvert = drv_ctrl.ainvert;
    assign bus.alu_bnegate = drv_ctrl.bnegate;
    assign bus.alu_op      = drv_ctrl.op;

    // Ready only in IDLE and never while reset is held
    assign bus.req_ready    = (state_q == S_IDLE) && rst_n;
    assign bus.rsp_valid    = (state_q == S_DONE);
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_overflow = rsp_overflow_q;
    assign bus.rsp_zero     = rsp_zero_q;
    assign bus.rsp_err      = rsp_err_q;

    // Sequencer FSM with operand, accumulator, counter and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            ctrl_q         <= CTRL_IDLE;
            a_q            <= '0;
            b_q            <= '0;
            acc_q          <= '0;
            cnt_q          <= '0;
            rsp_result_q   <= '0;
            rsp_overflow_q <= 1'b0;
            rsp_zero_q     <= 1'b0;
            rsp_err_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        a_q    <= bus.req_a;
                        b_q    <= bus.req_b;
                        ctrl_q <= dec_ctrl;
                        acc_q  <= '0;
                        cnt_q  <= '0;
                        if (dec_is_rsvd) begin
                            rsp_result_q   <= '0;
                            rsp_overflow_q <= 1'b0;
                            rsp_zero_q     <= 1'b0;
                            rsp_err_q      <= 1'b1;
                            state_q        <= S_DONE;
                        end else if (dec_is_mul) begin
                            state_q <= S_MUL;
                        end else begin
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    rsp_result_q   <= bus.alu_result;
                    rsp_overflow_q <= bus.alu_overflow;
                    rsp_zero_q     <= bus.alu_zero;
                    rsp_err_q      <= 1'b0;
                    state_q        <= S_DONE;
                end
                S_MUL: begin
                    acc_q <= bus.alu_result;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        // Low WIDTH product bits; overflow is not reported for MUL
                        rsp_result_q   <= bus.alu_result;
                        rsp_overflow_q <= 1'b0;
                        rsp_zero_q     <= bus.alu_zero;
                        rsp_err_q      <= 1'b0;
                        state_q        <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural 32-bit ALU attached.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_op_sequencer_if #(.WIDTH(32)) bus ();

    alu_op_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Team ALU: ainvert/bnegate condition the operands, bnegate is carry-in
    logic [31:0] ae, be, sm;
    logic        ov_raw;
    always_comb begin
        ae     = bus.alu_ainvert ? ~bus.alu_in1 : bus.alu_in1;
        be     = bus.alu_bnegate ? ~bus.alu_in2 : bus.alu_in2;
        sm     = ae + be + {31'b0, bus.alu_bnegate};
        ov_raw = (ae[31] == be[31]) && (sm[31] != ae[31]);
        case (bus.alu_op)
            2'b00:   bus.alu_result = ae & be;
            2'b01:   bus.alu_result = ae | be;
            2'b10:   bus.alu_result = sm;
            default: bus.alu_result = {31'b0, sm[31] ^ ov_raw};
        endcase
        bus.alu_overflow = (bus.alu_op == 2'b10) ? ov_raw : 1'b0;
        bus.alu_zero     = (bus.alu_result == 32'b0);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference semantics of each opcode, computed with plain arithmetic
    task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic ovf, output logic zero,
                          output logic err, output int lat);
        longint sa, sb, t;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ovf = 1'b0; err = 1'b0; lat = 2; res = '0;
        case (op)
            OPC_AND: res = a & b;
            OPC_OR:  res = a | b;
            OPC_NOR: res = ~(a | b);
            OPC_ADD: begin
                t = sa + sb; res = a + b;
                ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            OPC_SUB: begin
                t = sa - sb; res = a - b;
                ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            OPC_SLT: res = (sa < sb) ? 32'd1 : 32'd0;
            OPC_MUL: begin
                p = {32'b0, a} * {32'b0, b};
                res = p[31:0]; lat = 33;
            end
            default: begin res = '0; err = 1'b1; lat = 1; end
        endcase
        zero = err ? 1'b0 : (res == 32'b0);
    endtask

    // Issue one request, scramble req_* while busy, check the response,
    // optionally stall the response for 'stall' cycles, then handshake
    task automatic run_check(input string tag, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] er, input logic eo, input logic ez,
                             input logic ee, input int el, input int stall);
        int lat;
        @(negedge clk);
        check({tag, " req_ready idle"}, bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_opcode = op;
        bus.req_a      = a;
        bus.req_b      = b;
        @(posedge clk); #1;
        bus.req_valid  = 1'($urandom_range(0, 1));
        bus.req_opcode = 3'($urandom);
        bus.req_a      = $urandom;
        bus.req_b      = $urandom;
        lat = 1;
        while (!bus.rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, el);
        check({tag, " result"}, bus.rsp_result, er);
        check({tag, " overflow"}, bus.rsp_overflow, eo);
        check({tag, " zero"}, bus.rsp_zero, ez);
        check({tag, " err"}, bus.rsp_err, ee);
        check({tag, " alu_in idle"}, {bus.alu_in1, bus.alu_in2}, 0);
        check({tag, " alu ctrl idle"}, {bus.alu_ainvert, bus.alu_bnegate, bus.alu_op}, 0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            bus.req_valid = 1'b1;
            check({tag, " stall valid"}, bus.rsp_valid, 1);
            check({tag, " stall req_ready"}, bus.req_ready, 0);
            check({tag, " stall fields"},
                  {bus.rsp_result, bus.rsp_overflow, bus.rsp_zero, bus.rsp_err},
                  {er, eo, ez, ee});
        end
        // Handshake with a live request present: it must not be taken this cycle
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_opcode = OPC_ADD;
        bus.rsp_ready  = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        check({tag, " post hs rsp_valid"}, bus.rsp_valid, 0);
        check({tag, " post hs req_ready"}, bus.req_ready, 1);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        zero;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb, er;
        logic [2:0]  rop;
        logic        eo, ez, ee;
        int          el, hits;

        vecs[0]  = '{OPC_SUB,  32'd5,          32'd7,          32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 2};
        vecs[1]  = '{OPC_ADD,  32'h7FFFFFFF,   32'd1,          32'h80000000, 1'b1, 1'b0, 1'b0, 2};
        vecs[2]  = '{OPC_SLT,  32'hFFFFFFFD,   32'd2,          32'd1,        1'b0, 1'b0, 1'b0, 2};
        vecs[3]  = '{OPC_NOR,  32'hF0F0F0F0,   32'h0F0F0F00,   32'h0000000F, 1'b0, 1'b0, 1'b0, 2};
        vecs[4]  = '{OPC_MUL,  32'd1234,       32'd5678,       32'd7006652,  1'b0, 1'b0, 1'b0, 33};
        vecs[5]  = '{OPC_MUL,  32'd0,          32'h0000FFFF,   32'd0,        1'b0, 1'b1, 1'b0, 33};
        vecs[6]  = '{OPC_RSVD, 32'd123,        32'd456,        32'd0,        1'b0, 1'b0, 1'b1, 1};
        vecs[7]  = '{OPC_AND,  32'hF0F0F0F0,   32'hFF00FF00,   32'hF000F000, 1'b0, 1'b0, 1'b0, 2};
        vecs[8]  = '{OPC_OR,   32'h12340000,   32'h00005678,   32'h12345678, 1'b0, 1'b0, 1'b0, 2};
        vecs[9]  = '{OPC_SUB,  32'd3,          32'd3,          32'd0,        1'b0, 1'b1, 1'b0, 2};
        vecs[10] = '{OPC_SUB,  32'h80000000,   32'd1,          32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 2};
        vecs[11] = '{OPC_SLT,  32'd2,          32'hFFFFFFFD,   32'd0,        1'b0, 1'b1, 1'b0, 2};
        vecs[12] = '{OPC_MUL,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,        1'b0, 1'b0, 1'b0, 33};
        vecs[13] = '{OPC_ADD,  32'hFFFFFFFF,   32'd1,          32'd0,        1'b0, 1'b1, 1'b0, 2};

        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_opcode = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.rsp_ready  = 1'b0;

        // Reset state
        #1;
        check("reset req_ready", bus.req_ready, 0);
        check("reset rsp_valid", bus.rsp_valid, 0);
        check("reset rsp fields",
              {bus.rsp_result, bus.rsp_overflow, bus.rsp_zero, bus.rsp_err}, 0);
        check("reset alu drive",
              {bus.alu_in1, bus.alu_in2, bus.alu_ainvert, bus.alu_bnegate, bus.alu_op}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release req_ready", bus.req_ready, 1);

        // Directed vector table
        foreach (vecs[i])
            run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                      vecs[i].res, vecs[i].ovf, vecs[i].zero, vecs[i].err, vecs[i].lat, 0);

        // Backpressure: response held for five cycles
        run_check("backpressure", OPC_SUB, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 2, 5);

        // Randomized requests against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            ref_op(rop, ra, rb, er, eo, ez, ee, el);
            run_check($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, er, eo, ez, ee, el,
                      $urandom_range(0, 2));
        end

        // Reset pulsed during MUL iteration 10
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_opcode = OPC_MUL;
        bus.req_a      = 32'd1234;
        bus.req_b      = 32'd5678;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("mul busy req_ready", bus.req_ready, 0);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async rst req_ready", bus.req_ready, 0);
        check("async rst rsp_valid", bus.rsp_valid, 0);
        check("async rst rsp fields",
              {bus.rsp_result, bus.rsp_overflow, bus.rsp_zero, bus.rsp_err}, 0);
        check("async rst alu drive",
              {bus.alu_in1, bus.alu_in2, bus.alu_ainvert, bus.alu_bnegate, bus.alu_op}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) hits++;
        end
        check("no rsp after abort", hits, 0);
        run_check("add after reset", OPC_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
